// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - exception request/redirect bundle between pipeline and exc_ctrl
// master: pipeline side raising requests; slave: the exception controller.
interface exc_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             undef_req;
  logic [31:0]      undef_pc;
  logic             ovf_req;
  logic [31:0]      ovf_pc;
  logic             eret;
  logic             pc_redirect;
  logic [31:0]      pc_target;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic [31:0]      epc;
  logic [1:0]       cause;
  logic             in_handler;
  logic [CNT_W-1:0] masked_cnt;

  modport master (
    output undef_req, undef_pc, ovf_req, ovf_pc, eret,
    input  pc_redirect, pc_target, flush_if_id, flush_id_ex, flush_ex_mem,
    input  epc, cause, in_handler, masked_cnt
  );

  modport slave (
    input  undef_req, undef_pc, ovf_req, ovf_pc, eret,
    output pc_redirect, pc_target, flush_if_id, flush_id_ex, flush_ex_mem,
    output epc, cause, in_handler, masked_cnt
  );
endinterface

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception sequencing FSM: EPC/Cause capture, flush, redirect, return
// Every output is a register; the next-state logic precomputes next-cycle output values.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_FFFC,
  parameter int          CNT_W        = 4
) (
  input logic       clk,
  input logic       reset,
  exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_HANDLER,
    S_RETURN
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_UNDEF = 2'd1;
  localparam logic [1:0] CAUSE_ARITH = 2'd2;

  // flush bit order: {if_id, id_ex, ex_mem}
  localparam logic [2:0] FLUSH_OVF   = 3'b111;
  localparam logic [2:0] FLUSH_FRONT = 3'b110;

  state_t           state_q, state_d;
  logic [31:0]      epc_q, epc_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      target_q, target_d;
  logic [2:0]       flush_q, flush_d;
  logic             in_handler_q, in_handler_d;
  logic             any_req;

  assign any_req = bus.ovf_req | bus.undef_req;

  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    cnt_d        = cnt_q;
    redirect_d   = 1'b0;
    target_d     = 32'd0;
    flush_d      = 3'b000;
    in_handler_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // overflow wins: its instruction is older than the one in decode
        if (bus.ovf_req) begin
          epc_d      = bus.ovf_pc;
          cause_d    = CAUSE_ARITH;
          flush_d    = FLUSH_OVF;
          redirect_d = 1'b1;
          target_d   = HANDLER_ADDR;
          state_d    = S_FLUSH;
        end else if (bus.undef_req) begin
          epc_d      = bus.undef_pc;
          cause_d    = CAUSE_UNDEF;
          flush_d    = FLUSH_FRONT;
          redirect_d = 1'b1;
          target_d   = HANDLER_ADDR;
          state_d    = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d      = S_HANDLER;
        in_handler_d = 1'b1;
      end
      S_HANDLER: begin
        if (bus.eret) begin
          state_d    = S_RETURN;
          redirect_d = 1'b1;
          target_d   = epc_q + 32'd4;
          flush_d    = FLUSH_FRONT;
        end else begin
          in_handler_d = 1'b1;
        end
      end
      S_RETURN: begin
        state_d = S_IDLE;
        cause_d = CAUSE_NONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && any_req && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      epc_q        <= 32'd0;
      cause_q      <= CAUSE_NONE;
      cnt_q        <= '0;
      redirect_q   <= 1'b0;
      target_q     <= 32'd0;
      flush_q      <= 3'b000;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      cnt_q        <= cnt_d;
      redirect_q   <= redirect_d;
      target_q     <= target_d;
      flush_q      <= flush_d;
      in_handler_q <= in_handler_d;
    end
  end

  assign bus.pc_redirect  = redirect_q;
  assign bus.pc_target    = target_q;
  assign bus.flush_if_id  = flush_q[2];
  assign bus.flush_id_ex  = flush_q[1];
  assign bus.flush_ex_mem = flush_q[0];
  assign bus.epc          = epc_q;
  assign bus.cause        = cause_q;
  assign bus.in_handler   = in_handler_q;
  assign bus.masked_cnt   = cnt_q;

endmodule
